// File: rtl/alu_issue_wb_pkg.sv
// Shared opcode table, FSM encoding and ALU reference function for the issue/writeback stage.
package alu_pkg;

   localparam int ALU_W = 32;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_RSVD = 3'b011;
   localparam logic [2:0] OP_ANDN = 3'b100;
   localparam logic [2:0] OP_ORN  = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_ERR = 1'b1
   } state_t;

   // SLT compares unsigned; ADD/SUB wrap with no carry out.
   function automatic logic [ALU_W-1:0] alu_ref(input logic [2:0] op,
                                                input logic [ALU_W-1:0] a,
                                                input logic [ALU_W-1:0] b);
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_ADD:  return a + b;
         OP_ANDN: return a & ~b;
         OP_ORN:  return a | ~b;
         OP_SUB:  return a - b;
         OP_SLT:  return (a < b) ? ALU_W'(1) : '0;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_wb_if.sv
// Issue handshake and writeback bundle between the instruction source and alu_issue_wb.
interface alu_issue_wb_if #(
   parameter int DATA_W = 32,
   parameter int AW     = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [AW-1:0]     in_rd;
   logic [AW-1:0]     in_rs1;
   logic [AW-1:0]     in_rs2;
   logic              wb_valid;
   logic [AW-1:0]     wb_rd;
   logic [DATA_W-1:0] wb_data;

   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2,
      input  in_ready, wb_valid, wb_rd, wb_data
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2,
      output in_ready, wb_valid, wb_rd, wb_data
   );
endinterface

// File: rtl/alu_issue_wb_regfile.sv
// Architectural register file: two combinational reads, one synchronous write, r0 hardwired to zero.
module alu_regfile #(
   parameter  int DATA_W = 32,
   parameter  int REG_N  = 8,
   localparam int AW     = $clog2(REG_N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     ra1,
   output logic [DATA_W-1:0] rd1,
   input  logic [AW-1:0]     ra2,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] mem [REG_N];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_N; i++) mem[i] <= '0;
      end else if (we && wa != '0) begin
         mem[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
   assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_issue_wb.sv
// Operand issue + writeback around an external combinational ALU; halts on opcode 3'b011.
// Optional ALU_SELF_CHECK_EN adds a reference-model comparison and a sticky chk_err port.
module alu_issue_wb
   import alu_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int REG_N  = 8,
   localparam int AW     = $clog2(REG_N)
) (
   input  logic              clk,
   input  logic              rst,
   alu_issue_wb_if.slave     io,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_f,
   input  logic [DATA_W-1:0] alu_y,
   output logic              err,
   input  logic              err_clr
`ifdef ALU_SELF_CHECK_EN
   ,
   output logic              chk_err
`endif
);

   state_t            state_q;
   logic              err_q;
   logic              accept;
   logic              issue;
   logic [DATA_W-1:0] rf_rd1;
   logic [DATA_W-1:0] rf_rd2;
   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;

   logic              vld_p0;
   logic [2:0]        op_p0;
   logic [AW-1:0]     rd_p0;
   logic [DATA_W-1:0] a_p0;
   logic [DATA_W-1:0] b_p0;

   logic              vld_p1;
   logic [AW-1:0]     rd_p1;
   logic [DATA_W-1:0] data_p1;

   // The instruction in EX has not been written back yet, so its result is bypassed from alu_y.
   function automatic logic [DATA_W-1:0] fwd_sel(input logic              ex_vld,
                                                 input logic [AW-1:0]     ex_rd,
                                                 input logic [AW-1:0]     rs,
                                                 input logic [DATA_W-1:0] ex_y,
                                                 input logic [DATA_W-1:0] rf_val);
      if (ex_vld && ex_rd == rs && rs != '0) return ex_y;
      return rf_val;
   endfunction

   assign io.in_ready = (state_q == ST_RUN) && !rst;
   assign accept      = io.in_valid && io.in_ready;
   assign issue       = accept && (io.in_op != OP_RSVD);

   assign opnd_a = fwd_sel(vld_p0, rd_p0, io.in_rs1, alu_y, rf_rd1);
   assign opnd_b = fwd_sel(vld_p0, rd_p0, io.in_rs2, alu_y, rf_rd2);

   alu_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (io.in_rs1),
      .rd1 (rf_rd1),
      .ra2 (io.in_rs2),
      .rd2 (rf_rd2),
      .we  (vld_p0),
      .wa  (rd_p0),
      .wd  (alu_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: if (accept && io.in_op == OP_RSVD) begin
               state_q <= ST_ERR;
               err_q   <= 1'b1;
            end
            ST_ERR: if (err_clr) begin
               state_q <= ST_RUN;
               err_q   <= 1'b0;
            end
            default: begin
               state_q <= ST_RUN;
               err_q   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         op_p0   <= '0;
         rd_p0   <= '0;
         a_p0    <= '0;
         b_p0    <= '0;
         vld_p1  <= 1'b0;
         rd_p1   <= '0;
         data_p1 <= '0;
      end else begin
         // p0: EX register, loaded at accept; holds last operands while empty
         vld_p0 <= issue;
         if (issue) begin
            op_p0 <= io.in_op;
            rd_p0 <= io.in_rd;
            a_p0  <= opnd_a;
            b_p0  <= opnd_b;
         end
         // p1: writeback, captures the ALU result one cycle after issue
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            rd_p1   <= rd_p0;
            data_p1 <= alu_y;
         end
      end
   end

   assign alu_a       = a_p0;
   assign alu_b       = b_p0;
   assign alu_f       = op_p0;
   assign io.wb_valid = vld_p1;
   assign io.wb_rd    = rd_p1;
   assign io.wb_data  = data_p1;
   assign err         = err_q;

`ifdef ALU_SELF_CHECK_EN
   logic [DATA_W-1:0] ref_y;
   assign ref_y = DATA_W'(alu_ref(op_p0, ALU_W'(a_p0), ALU_W'(b_p0)));

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_err <= 1'b0;
      end else if (vld_p0 && alu_y != ref_y) begin
         chk_err <= 1'b1;
`ifndef SYNTHESIS
         $display("alu_issue_wb self-check: op=%b a=%h b=%h expected=%h actual=%h",
                  op_p0, a_p0, b_p0, ref_y, alu_y);
`endif
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_wb.sv
// Randomized and directed bench for alu_issue_wb against a sequential-ISA reference model.
module tb_alu_issue_wb;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        err_clr;
   logic        err;
   logic [31:0] alu_a, alu_b, alu_y;
   logic [2:0]  alu_f;
`ifdef ALU_SELF_CHECK_EN
   logic        chk_err;
`endif

   always #5 clk = ~clk;

   alu_issue_wb_if #(.DATA_W(32), .AW(3)) bus ();

   alu_issue_wb #(.DATA_W(32), .REG_N(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .io      (bus),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_f   (alu_f),
      .alu_y   (alu_y),
      .err     (err),
      .err_clr (err_clr)
`ifdef ALU_SELF_CHECK_EN
      ,
      .chk_err (chk_err)
`endif
   );

   // Behavioural ALU written straight from the opcode table.
   function automatic logic [31:0] tb_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a + b;
         3'd4: return a & ~b;
         3'd5: return a | ~b;
         3'd6: return a - b;
         3'd7: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_y = tb_alu(alu_f, alu_a, alu_b);

   int n_cmp = 0;
   int n_bad = 0;

   // Architectural model: instructions execute in order at accept; writeback is reported one cycle later.
   logic [31:0] m_rf [8];
   logic        pend_v;
   logic [2:0]  pend_rd;
   logic [31:0] pend_d;
   logic        exp_wv, exp_err;
   logic [2:0]  exp_wrd, exp_f;
   logic [31:0] exp_wd, exp_a, exp_b;

   task automatic model_edge();
      logic [31:0] a, b, r;
      if (rst) begin
         for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
         pend_v = 0; pend_rd = 0; pend_d = 0;
         exp_wv = 0; exp_wrd = 0; exp_wd = 0; exp_err = 0;
         exp_a = 0; exp_b = 0; exp_f = 0;
      end else begin
         exp_wv = pend_v;
         if (pend_v) begin exp_wrd = pend_rd; exp_wd = pend_d; end
         pend_v = 0;
         if (bus.in_valid && !exp_err) begin
            if (bus.in_op == 3'b011) begin
               exp_err = 1;
            end else begin
               a = m_rf[bus.in_rs1];
               b = m_rf[bus.in_rs2];
               r = tb_alu(bus.in_op, a, b);
               exp_a = a; exp_b = b; exp_f = bus.in_op;
               if (bus.in_rd != 0) m_rf[bus.in_rd] = r;
               pend_v = 1; pend_rd = bus.in_rd; pend_d = r;
            end
         end else if (exp_err && err_clr) begin
            exp_err = 0;
         end
      end
   endtask

   function automatic logic [14:0] mk(input logic r, input logic c, input logic v, input logic [2:0] op,
                                      input logic [2:0] rd, input logic [2:0] s1, input logic [2:0] s2);
      return {r, c, v, op, rd, s1, s2};
   endfunction

   // Apply one cycle of stimulus, advance the model, and land #1 after the clock edge.
   task automatic run_step(input logic [14:0] s);
      {rst, err_clr, bus.in_valid, bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2} = s;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      run_step(mk(1, 0, 1, OP_ORN, 3'd1, 3'd0, 3'd0));
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_bad++; $display("FAIL reset_ready act=%b exp=0", bus.in_ready);
      end
      run_step(mk(0, 0, 0, OP_AND, 3'd0, 3'd0, 3'd0));
      n_cmp++;
      if ({bus.in_ready, bus.wb_valid, bus.wb_rd, bus.wb_data, err, alu_f, alu_a, alu_b} !== {1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0}) begin
         n_bad++;
         $display("FAIL reset_state act rdy=%b wv=%b rd=%0d wd=%h err=%b f=%b a=%h b=%h exp rdy=1 rest=0",
                  bus.in_ready, bus.wb_valid, bus.wb_rd, bus.wb_data, err, alu_f, alu_a, alu_b);
      end
   endtask

   // Runs a table; each step gets the full model comparison, plus a directed writeback check where given.
   task automatic run_table(input string name, input logic [14:0] tbl[$],
                            input logic [3:0] chk_wv[$], input logic [31:0] chk_wd[$]);
      for (int i = 0; i < tbl.size(); i++) begin
         run_step(tbl[i]);
         n_cmp++;
         if ({bus.wb_valid, bus.wb_rd, bus.wb_data, err, bus.in_ready, alu_f, alu_a, alu_b} !==
             {exp_wv, exp_wrd, exp_wd, exp_err, ~rst & ~exp_err, exp_f, exp_a, exp_b}) begin
            n_bad++;
            $display("FAIL %s_pipe step=%0d act=%h exp=%h", name, i,
                     {bus.wb_valid, bus.wb_rd, bus.wb_data, err, bus.in_ready, alu_f, alu_a, alu_b},
                     {exp_wv, exp_wrd, exp_wd, exp_err, ~rst & ~exp_err, exp_f, exp_a, exp_b});
         end
         if (chk_wv[i][3]) begin
            n_cmp++;
            if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {chk_wv[i][2:0] != 3'd7 ? 1'b1 : 1'b0,
                                                            chk_wv[i][2:0] != 3'd7 ? chk_wv[i][2:0] : bus.wb_rd,
                                                            chk_wv[i][2:0] != 3'd7 ? chk_wd[i] : bus.wb_data}) begin
               n_bad++;
               $display("FAIL %s_wb step=%0d act wv=%b rd=%0d data=%h exp rd=%0d data=%h (rd 7 = no writeback)",
                        name, i, bus.wb_valid, bus.wb_rd, bus.wb_data, chk_wv[i][2:0], chk_wd[i]);
            end
         end
      end
   endtask

   task automatic test_basic();
      run_table("basic",
                '{mk(0,0,1,OP_ADD,1,0,0), mk(0,0,0,OP_AND,0,0,0)},
                '{4'h0, 4'h9}, '{32'd0, 32'd0});
   endtask

   task automatic test_orn();
      run_table("orn",
                '{mk(0,0,1,OP_SUB,3,0,0), mk(0,0,1,OP_ORN,1,0,0), mk(0,0,0,OP_AND,0,0,0)},
                '{4'h0, 4'hB, 4'h9}, '{32'd0, 32'd0, 32'hFFFF_FFFF});
   endtask

   task automatic test_back_to_back();
      run_table("b2b",
                '{mk(0,0,1,OP_ORN,1,0,0), mk(0,0,1,OP_ADD,2,1,1), mk(0,0,1,OP_SLT,3,0,2),
                  mk(0,0,0,OP_AND,0,0,0)},
                '{4'h0, 4'h9, 4'hA, 4'hB}, '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1});
      n_cmp++;
      run_step(mk(0, 0, 0, OP_AND, 0, 0, 0));
      if (bus.wb_valid !== 1'b0) begin
         n_bad++; $display("FAIL b2b_tail act wv=%b exp wv=0", bus.wb_valid);
      end
   endtask

   task automatic test_illegal();
      // Step 1 issues 011; steps 2-6 hold in_valid; step 7 pulses err_clr; step 8 must be accepted again.
      run_table("illegal",
                '{mk(0,0,1,OP_ORN,1,0,0), mk(0,0,1,OP_RSVD,6,1,1),
                  mk(0,0,1,OP_ADD,2,1,1), mk(0,0,1,OP_ADD,2,1,1), mk(0,0,1,OP_ADD,2,1,1),
                  mk(0,0,1,OP_ADD,2,1,1), mk(0,0,1,OP_ADD,2,1,1),
                  mk(0,1,0,OP_AND,0,0,0), mk(0,0,1,OP_ADD,2,1,1), mk(0,0,0,OP_AND,0,0,0)},
                '{4'h0, 4'h9, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hA},
                '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE});
   endtask

   task automatic test_err_flags();
      run_step(mk(0, 0, 1, OP_RSVD, 2, 0, 0));
      n_cmp++;
      if ({err, bus.in_ready} !== 2'b10) begin
         n_bad++; $display("FAIL err_set act err=%b rdy=%b exp err=1 rdy=0", err, bus.in_ready);
      end
      run_step(mk(0, 1, 0, OP_AND, 0, 0, 0));
      n_cmp++;
      if ({err, bus.in_ready} !== 2'b01) begin
         n_bad++; $display("FAIL err_clr act err=%b rdy=%b exp err=0 rdy=1", err, bus.in_ready);
      end
   endtask

   task automatic test_r0_write();
      run_table("r0",
                '{mk(0,0,1,OP_ORN,0,0,0), mk(0,0,1,OP_ADD,4,0,0), mk(0,0,0,OP_AND,0,0,0)},
                '{4'h0, 4'h8, 4'hC}, '{32'd0, 32'hFFFF_FFFF, 32'd0});
   endtask

   task automatic test_reset_mid();
      run_table("rstmid",
                '{mk(0,0,1,OP_ORN,5,0,0), mk(1,0,0,OP_AND,0,0,0), mk(0,0,0,OP_AND,0,0,0),
                  mk(0,0,1,OP_ADD,6,5,0), mk(0,0,0,OP_AND,0,0,0)},
                '{4'h0, 4'hF, 4'hF, 4'h0, 4'hE}, '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0});
   endtask

   task automatic test_random();
      logic [14:0] s;
      for (int i = 0; i < 400; i++) begin
         s = mk($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
         run_step(s);
         n_cmp++;
         if ({bus.wb_valid, bus.wb_rd, bus.wb_data, err, bus.in_ready, alu_f, alu_a, alu_b} !==
             {exp_wv, exp_wrd, exp_wd, exp_err, ~rst & ~exp_err, exp_f, exp_a, exp_b}) begin
            n_bad++;
            $display("FAIL random_pipe cyc=%0d act=%h exp=%h", i,
                     {bus.wb_valid, bus.wb_rd, bus.wb_data, err, bus.in_ready, alu_f, alu_a, alu_b},
                     {exp_wv, exp_wrd, exp_wd, exp_err, ~rst & ~exp_err, exp_f, exp_a, exp_b});
         end
      end
   endtask

   task automatic test_alu_ref();
      logic [31:0] a, b;
      logic [2:0]  op;
      for (int i = 0; i < 48; i++) begin
         op = 3'(i % 8);
         a  = (i < 8) ? 32'hFFFF_FFFF : $urandom;
         b  = (i < 16 && i >= 8) ? a : ((i < 8) ? 32'd1 : $urandom);
         n_cmp++;
         if (alu_ref(op, a, b) !== tb_alu(op, a, b)) begin
            n_bad++;
            $display("FAIL alu_ref op=%b a=%h b=%h act=%h exp=%h", op, a, b, alu_ref(op, a, b), tb_alu(op, a, b));
         end
      end
   endtask

   initial begin
      rst = 1'b1; err_clr = 1'b0;
      bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_rd = 3'd0; bus.in_rs1 = 3'd0; bus.in_rs2 = 3'd0;
      test_reset();
      test_basic();
      test_orn();
      test_back_to_back();
      test_illegal();
      test_err_flags();
      test_r0_write();
      test_reset_mid();
      test_random();
      test_alu_ref();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
